// File: rtl/fp_mult_seq.sv
// Sequential IEEE754 single-precision multiplier: shift-and-add significand product
// through one ripple-carry adder, then normalise, classify and hold the result.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one shift-and-add step per cycle, MANT_W cycles
// NORM  | normalise product, resolve special cases, register result and flags
// OUT   | result presented until the consumer takes it
module fp_mult_seq #(
  parameter int MANT_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  localparam int PROD_W = 2 * MANT_W;
  localparam int FRAC_W = MANT_W - 1;
  localparam int CNT_W  = $clog2(MANT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, NORM, OUT} state_t;

  state_t state, state_nxt;

  logic              sign;
  logic [7:0]        ea, eb;
  logic              a_fnz, b_fnz;
  logic [9:0]        esum;
  logic [PROD_W-1:0] mcand;
  logic [MANT_W-1:0] mplr;
  logic [PROD_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic [PROD_W-1:0] add_sum;
  logic [9:0]        e_norm;
  logic [FRAC_W-1:0] mant_norm;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              is_nan, is_inf, is_zero, e_big, e_small;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = NORM;
      NORM: state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The only wide adder: bit-serial carry chain, carry-out discarded.
  always_comb begin
    logic carry;
    carry   = 1'b0;
    add_sum = '0;
    for (int i = 0; i < PROD_W; i++) begin
      add_sum[i] = acc[i] ^ mcand[i] ^ carry;
      carry      = (acc[i] & mcand[i]) | (carry & (acc[i] ^ mcand[i]));
    end
  end

  assign e_norm    = esum - 10'd127 + {9'b0, acc[PROD_W-1]};
  assign mant_norm = acc[PROD_W-1] ? acc[PROD_W-2 -: FRAC_W] : acc[PROD_W-3 -: FRAC_W];

  assign a_nan   = (ea == 8'hFF) && a_fnz;
  assign b_nan   = (eb == 8'hFF) && b_fnz;
  assign a_inf   = (ea == 8'hFF) && !a_fnz;
  assign b_inf   = (eb == 8'hFF) && !b_fnz;
  assign a_zero  = (ea == 8'h00) && !a_fnz;
  assign b_zero  = (eb == 8'h00) && !b_fnz;
  assign is_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign is_inf  = (ea == 8'hFF) || (eb == 8'hFF);
  assign is_zero = (ea == 8'h00) || (eb == 8'h00);
  assign e_big   = $signed(e_norm) >= $signed(10'd255);
  assign e_small = $signed(e_norm) <= $signed(10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign   <= 1'b0;
      ea     <= '0;
      eb     <= '0;
      a_fnz  <= 1'b0;
      b_fnz  <= 1'b0;
      esum   <= '0;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= a[31] ^ b[31];
            ea    <= a[30:23];
            eb    <= b[30:23];
            a_fnz <= |a[FRAC_W-1:0];
            b_fnz <= |b[FRAC_W-1:0];
            esum  <= {2'b0, a[30:23]} + {2'b0, b[30:23]};
            mcand <= {{MANT_W{1'b0}}, 1'b1, a[FRAC_W-1:0]};
            mplr  <= {1'b1, b[FRAC_W-1:0]};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (mplr[0]) acc <= add_sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
        end
        NORM: begin
          ovf <= 1'b0;
          unf <= 1'b0;
          if (is_nan) begin
            result <= 32'h7FC0_0000;
          end else if (is_inf) begin
            result <= {sign, 8'hFF, 23'b0};
          end else if (is_zero) begin
            result <= {sign, 31'b0};
          end else if (e_big) begin
            result <= {sign, 8'hFF, 23'b0};
            ovf    <= 1'b1;
          end else if (e_small) begin
            result <= {sign, 31'b0};
            unf    <= 1'b1;
          end else begin
            result <= {sign, e_norm[7:0], mant_norm};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
